ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Two-requester round-robin arbiter in front of a simple
//                dual-port RAM (separate write and read ports on one clock).
//                Issues registered RAM write/read commands, tracks read
//                ownership through an RD_LAT-deep tag pipeline so each return
//                reaches the right requester, and runs a full-RAM clear
//                sequence on demand or, optionally, out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 18,
    parameter int RD_LAT     = 1,
    parameter bit CLR_ON_RST = 1'b0
) (
    input  logic              Clk,
    input  logic              Rst,

    // Requester A
    input  logic              Req_A,
    input  logic              We_A,
    input  logic [ADDR_W-1:0] Addr_A,
    input  logic [DATA_W-1:0] Wd_A,
    input  logic [1:0]        Ben_A,
    output logic              Gnt_A,
    output logic              Rd_Valid_A,

    // Requester B
    input  logic              Req_B,
    input  logic              We_B,
    input  logic [ADDR_W-1:0] Addr_B,
    input  logic [DATA_W-1:0] Wd_B,
    input  logic [1:0]        Ben_B,
    output logic              Gnt_B,
    output logic              Rd_Valid_B,

    // Shared read return
    output logic [DATA_W-1:0] Rd_Data,

    // Clear control
    input  logic              Clr_Start,
    output logic              Clr_Busy,
    output logic              Clr_Done,

    // RAM side
    output logic [ADDR_W-1:0] Mem_WA,
    output logic [ADDR_W-1:0] Mem_RA,
    output logic [DATA_W-1:0] Mem_WD,
    output logic [1:0]        Mem_WEN,
    output logic              Mem_WClk_En,
    output logic              Mem_RClk_En,
    input  logic [DATA_W-1:0] Mem_RD
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]        c_st_arb   = 1'b0;
    localparam logic [0:0]        c_st_clear = 1'b1;
    localparam logic [ADDR_W-1:0] c_clr_last = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    logic [0:0]        r_state;
    logic              r_prio_b;      // 1: B wins the next contention
    logic [ADDR_W-1:0] r_clr_cnt;     // next clear address to issue

    logic [ADDR_W-1:0] r_mem_wa;
    logic [ADDR_W-1:0] r_mem_ra;
    logic [DATA_W-1:0] r_mem_wd;
    logic [1:0]        r_mem_wen;
    logic              r_wclk_en;
    logic              r_rclk_en;
    logic              r_clr_busy;
    logic              r_clr_done;

    // Read ownership pipeline: valid bit and owner (1 = B) per stage
    logic [RD_LAT-1:0] r_tag_v;
    logic [RD_LAT-1:0] r_tag_b;
    logic              r_rd_valid_a;
    logic              r_rd_valid_b;

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic              w_arb_open;
    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wd;
    logic [1:0]        w_ben;
    logic              w_wr_issue;
    logic              w_rd_issue;

    // Grants are only possible in ARB, out of reset, and when no clear is
    // being requested in the same cycle (the clear request wins).
    assign w_arb_open = !Rst && (r_state == c_st_arb) && !Clr_Start;

    // Round-robin: a lone requester always wins, on contention the pointer
    // decides.
    assign w_gnt_a = w_arb_open && Req_A && (!Req_B || !r_prio_b);
    assign w_gnt_b = w_arb_open && Req_B && (!Req_A ||  r_prio_b);

    // Select the winning request's payload
    assign w_we   = w_gnt_b ? We_B   : We_A;
    assign w_addr = w_gnt_b ? Addr_B : Addr_A;
    assign w_wd   = w_gnt_b ? Wd_B   : Wd_A;
    assign w_ben  = w_gnt_b ? Ben_B  : Ben_A;

    assign w_wr_issue = (w_gnt_a || w_gnt_b) &&  w_we;
    assign w_rd_issue = (w_gnt_a || w_gnt_b) && !w_we;

    // ------------------------------------------------------------------------
    // FSM, pointer, clear counter and registered RAM command
    // ------------------------------------------------------------------------
    // One command slot per cycle: either an arbitrated access or a clear write.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            // With CLR_ON_RST the FSM leaves reset in CLEAR with the counter at
            // zero, so the first cycle after release issues address 0.
            r_state    <= CLR_ON_RST ? c_st_clear : c_st_arb;
            r_prio_b   <= 1'b0;
            r_clr_cnt  <= '0;
            r_mem_wa   <= '0;
            r_mem_ra   <= '0;
            r_mem_wd   <= '0;
            r_mem_wen  <= 2'b00;
            r_wclk_en  <= 1'b0;
            r_rclk_en  <= 1'b0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            // Strobes default low; addresses and data hold their last value.
            r_mem_wen  <= 2'b00;
            r_wclk_en  <= 1'b0;
            r_rclk_en  <= 1'b0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;

            case (r_state)
                c_st_arb: begin
                    if (Clr_Start) begin
                        // Enter CLEAR and issue address 0 right away so that
                        // Clr_Busy lines up with every clear write.
                        r_state    <= c_st_clear;
                        r_mem_wa   <= '0;
                        r_mem_wd   <= '0;
                        r_mem_wen  <= 2'b11;
                        r_wclk_en  <= 1'b1;
                        r_clr_busy <= 1'b1;
                        r_clr_done <= (c_clr_last == '0);
                        r_clr_cnt  <= c_one;
                    end else begin
                        if (w_gnt_a) begin
                            r_prio_b <= 1'b1;
                        end else if (w_gnt_b) begin
                            r_prio_b <= 1'b0;
                        end

                        if (w_wr_issue) begin
                            r_mem_wa  <= w_addr;
                            r_mem_wd  <= w_wd;
                            r_mem_wen <= w_ben;
                            r_wclk_en <= 1'b1;
                        end

                        if (w_rd_issue) begin
                            r_mem_ra  <= w_addr;
                            r_rclk_en <= 1'b1;
                        end
                    end
                end

                c_st_clear: begin
                    if (r_clr_done) begin
                        // Final address is on the bus this cycle; arbitration
                        // resumes next cycle. The counter has already wrapped.
                        r_state <= c_st_arb;
                    end else begin
                        r_mem_wa   <= r_clr_cnt;
                        r_mem_wd   <= '0;
                        r_mem_wen  <= 2'b11;
                        r_wclk_en  <= 1'b1;
                        r_clr_busy <= 1'b1;
                        r_clr_done <= (r_clr_cnt == c_clr_last);
                        r_clr_cnt  <= r_clr_cnt + c_one;
                    end
                end

                default: begin
                    r_state <= c_st_arb;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read tag pipeline
    // ------------------------------------------------------------------------
    generate
        if (RD_LAT == 1) begin : g_tag_lat1
            // Single stage: capture the owner of the read issued this cycle.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    r_tag_v <= '0;
                    r_tag_b <= '0;
                end else begin
                    r_tag_v <= w_rd_issue;
                    r_tag_b <= w_gnt_b;
                end
            end
        end else begin : g_tag_latn
            // Shift register; keeps running through CLEAR so in-flight reads
            // still return.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    r_tag_v <= '0;
                    r_tag_b <= '0;
                end else begin
                    r_tag_v <= {r_tag_v[RD_LAT-2:0], w_rd_issue};
                    r_tag_b <= {r_tag_b[RD_LAT-2:0], w_gnt_b};
                end
            end
        end
    endgenerate

    // Route the tag leaving the pipeline to the owning requester's valid.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rd_valid_a <= 1'b0;
            r_rd_valid_b <= 1'b0;
        end else begin
            r_rd_valid_a <= r_tag_v[RD_LAT-1] && !r_tag_b[RD_LAT-1];
            r_rd_valid_b <= r_tag_v[RD_LAT-1] &&  r_tag_b[RD_LAT-1];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Gnt_A       = w_gnt_a;
    assign Gnt_B       = w_gnt_b;
    assign Rd_Valid_A  = r_rd_valid_a;
    assign Rd_Valid_B  = r_rd_valid_b;
    // Read data is a pass-through of the RAM, held at zero during reset.
    assign Rd_Data     = Rst ? '0 : Mem_RD;
    assign Clr_Busy    = r_clr_busy;
    assign Clr_Done    = r_clr_done;
    assign Mem_WA      = r_mem_wa;
    assign Mem_RA      = r_mem_ra;
    assign Mem_WD      = r_mem_wd;
    assign Mem_WEN     = r_mem_wen;
    assign Mem_WClk_En = r_wclk_en;
    assign Mem_RClk_En = r_rclk_en;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Self-checking bench for ram_port_arbiter. Directed scenarios
//                followed by randomized traffic, all compared each cycle
//                against a transaction-level reference model (last-granted
//                flag, clear position, queue of scheduled read returns).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 18;
    localparam int RD_LAT = 2;
    localparam int NWORDS = 1 << ADDR_W;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Req_A, We_A, Req_B, We_B;
    logic [ADDR_W-1:0] Addr_A, Addr_B;
    logic [DATA_W-1:0] Wd_A, Wd_B;
    logic [1:0]        Ben_A, Ben_B;
    logic              Gnt_A, Gnt_B, Rd_Valid_A, Rd_Valid_B;
    logic [DATA_W-1:0] Rd_Data;
    logic              Clr_Start, Clr_Busy, Clr_Done;
    logic [ADDR_W-1:0] Mem_WA, Mem_RA;
    logic [DATA_W-1:0] Mem_WD;
    logic [1:0]        Mem_WEN;
    logic              Mem_WClk_En, Mem_RClk_En;
    logic [DATA_W-1:0] Mem_RD;

    always #5 Clk = ~Clk;

    ram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .CLR_ON_RST(1'b0)
    ) u_dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Req_A      (Req_A),
        .We_A       (We_A),
        .Addr_A     (Addr_A),
        .Wd_A       (Wd_A),
        .Ben_A      (Ben_A),
        .Gnt_A      (Gnt_A),
        .Rd_Valid_A (Rd_Valid_A),
        .Req_B      (Req_B),
        .We_B       (We_B),
        .Addr_B     (Addr_B),
        .Wd_B       (Wd_B),
        .Ben_B      (Ben_B),
        .Gnt_B      (Gnt_B),
        .Rd_Valid_B (Rd_Valid_B),
        .Rd_Data    (Rd_Data),
        .Clr_Start  (Clr_Start),
        .Clr_Busy   (Clr_Busy),
        .Clr_Done   (Clr_Done),
        .Mem_WA     (Mem_WA),
        .Mem_RA     (Mem_RA),
        .Mem_WD     (Mem_WD),
        .Mem_WEN    (Mem_WEN),
        .Mem_WClk_En(Mem_WClk_En),
        .Mem_RClk_En(Mem_RClk_En),
        .Mem_RD     (Mem_RD)
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    typedef struct {
        int due;
        bit own_b;
    } rd_ret_t;

    rd_ret_t           rd_q[$];
    int                n_chk = 0;
    int                n_fail = 0;
    int                cyc = 0;
    bit                m_known = 1'b0;
    int                m_clr_idx = -1;   // clear address shown this cycle, -1 if arbitrating
    bit                m_last_b = 1'b1;  // B granted most recently -> A has priority
    logic [ADDR_W-1:0] e_wa, e_ra;
    logic [DATA_W-1:0] e_wd;
    logic [1:0]        e_wen;
    bit                e_wclk, e_rclk, e_busy, e_done;

    int                n_done_seen = 0;
    int                n_busy_seen = 0;
    int                last_rva_cyc = -100;
    int                last_rvb_cyc = -100;
    bit                last_gnt_a = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: inputs are already applied; check at the falling edge,
    // advance the model, then step past the next rising edge.
    task automatic run_cycle();
        bit                ga, gb, rva, rvb, wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [1:0]        be;
        rd_ret_t           ent;

        @(negedge Clk);
        rva = 1'b0;
        rvb = 1'b0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            if (rd_q[0].own_b) rvb = 1'b1;
            else               rva = 1'b1;
            void'(rd_q.pop_front());
        end

        ga = 1'b0;
        gb = 1'b0;
        if (!Rst && m_clr_idx < 0 && !Clr_Start) begin
            if (Req_A && Req_B) begin
                ga = m_last_b;
                gb = !m_last_b;
            end else begin
                ga = Req_A;
                gb = Req_B;
            end
        end

        if (m_known) begin
            chk("gnt_a",    32'(Gnt_A),       32'(ga));
            chk("gnt_b",    32'(Gnt_B),       32'(gb));
            chk("mem_wa",   32'(Mem_WA),      32'(e_wa));
            chk("mem_wd",   32'(Mem_WD),      32'(e_wd));
            chk("mem_wen",  32'(Mem_WEN),     32'(e_wen));
            chk("wclk_en",  32'(Mem_WClk_En), 32'(e_wclk));
            chk("mem_ra",   32'(Mem_RA),      32'(e_ra));
            chk("rclk_en",  32'(Mem_RClk_En), 32'(e_rclk));
            chk("clr_busy", 32'(Clr_Busy),    32'(e_busy));
            chk("clr_done", 32'(Clr_Done),    32'(e_done));
            chk("rd_val_a", 32'(Rd_Valid_A),  32'(rva));
            chk("rd_val_b", 32'(Rd_Valid_B),  32'(rvb));
            chk("rd_data",  32'(Rd_Data),     Rst ? 32'd0 : 32'(Mem_RD));
        end

        if (Clr_Done === 1'b1)   n_done_seen++;
        if (Clr_Busy === 1'b1)   n_busy_seen++;
        if (Rd_Valid_A === 1'b1) last_rva_cyc = cyc;
        if (Rd_Valid_B === 1'b1) last_rvb_cyc = cyc;
        last_gnt_a = (Gnt_A === 1'b1);

        if (Rst) begin
            e_wa = '0; e_ra = '0; e_wd = '0; e_wen = '0;
            e_wclk = 1'b0; e_rclk = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            rd_q.delete();
            m_clr_idx = -1;
            m_last_b  = 1'b1;
            m_known   = 1'b1;
        end else begin
            e_wen = '0; e_wclk = 1'b0; e_rclk = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            if (m_clr_idx >= 0) begin
                if (m_clr_idx == NWORDS - 1) begin
                    m_clr_idx = -1;
                end else begin
                    m_clr_idx++;
                    e_wa = ADDR_W'(m_clr_idx); e_wd = '0; e_wen = 2'b11;
                    e_wclk = 1'b1; e_busy = 1'b1; e_done = (m_clr_idx == NWORDS - 1);
                end
            end else if (Clr_Start) begin
                m_clr_idx = 0;
                e_wa = '0; e_wd = '0; e_wen = 2'b11; e_wclk = 1'b1; e_busy = 1'b1;
            end else if (ga || gb) begin
                m_last_b = gb;
                wr = ga ? We_A   : We_B;
                a  = ga ? Addr_A : Addr_B;
                d  = ga ? Wd_A   : Wd_B;
                be = ga ? Ben_A  : Ben_B;
                if (wr) begin
                    e_wa = a; e_wd = d; e_wen = be; e_wclk = 1'b1;
                end else begin
                    e_ra = a; e_rclk = 1'b1;
                    ent.due   = cyc + 1 + RD_LAT;
                    ent.own_b = gb;
                    rd_q.push_back(ent);
                end
            end
        end

        @(posedge Clk);
        #1;
        cyc++;
        if (ga) Req_A = 1'b0;
        if (gb) Req_B = 1'b0;
        Mem_RD = DATA_W'($urandom);
    endtask

    task automatic new_req_a();
        Req_A = 1'b1; We_A = 1'($urandom_range(0, 1));
        Addr_A = ADDR_W'($urandom); Wd_A = DATA_W'($urandom); Ben_A = 2'($urandom);
    endtask

    task automatic new_req_b();
        Req_B = 1'b1; We_B = 1'($urandom_range(0, 1));
        Addr_B = ADDR_W'($urandom); Wd_B = DATA_W'($urandom); Ben_B = 2'($urandom);
    endtask

    int t0, b0, d0;

    initial begin
        Rst = 1'b1; Clr_Start = 1'b0;
        Req_A = 1'b0; We_A = 1'b0; Addr_A = '0; Wd_A = '0; Ben_A = '0;
        Req_B = 1'b0; We_B = 1'b0; Addr_B = '0; Wd_B = '0; Ben_B = '0;
        Mem_RD = '0;
        @(posedge Clk);
        #1;
        repeat (3) run_cycle();
        Rst = 1'b0;

        // Single write from A
        Req_A = 1'b1; We_A = 1'b1; Addr_A = 4'd5; Wd_A = 18'h2AA55; Ben_A = 2'b11;
        run_cycle();
        chk("t_wr_gnt", 32'(last_gnt_a),  32'd1);
        chk("t_wr_wa",  32'(Mem_WA),      32'd5);
        chk("t_wr_wd",  32'(Mem_WD),      32'h2AA55);
        chk("t_wr_wen", 32'(Mem_WEN),     32'd3);
        chk("t_wr_en",  32'(Mem_WClk_En), 32'd1);
        run_cycle();

        // Contention right after reset: A,B,A,B
        Rst = 1'b1;
        run_cycle();
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Req_A = 1'b1; We_A = 1'b1; Addr_A = 4'd1; Wd_A = 18'h00111; Ben_A = 2'b01;
            Req_B = 1'b1; We_B = 1'b1; Addr_B = 4'd2; Wd_B = 18'h00222; Ben_B = 2'b10;
            run_cycle();
            chk("t_rr_wa", 32'(Mem_WA), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        Req_A = 1'b0; Req_B = 1'b0;
        run_cycle();

        // Back-to-back reads with alternating owners
        t0 = cyc;
        Req_A = 1'b1; We_A = 1'b0; Addr_A = 4'd3;
        run_cycle();
        Req_B = 1'b1; We_B = 1'b0; Addr_B = 4'd4;
        run_cycle();
        repeat (5) run_cycle();
        chk("t_rd_lat_a", 32'(last_rva_cyc - t0), 32'd3);
        chk("t_rd_lat_b", 32'(last_rvb_cyc - t0), 32'd4);

        // Clear with a same-cycle request from A
        b0 = n_busy_seen; d0 = n_done_seen;
        Clr_Start = 1'b1;
        Req_A = 1'b1; We_A = 1'b1; Addr_A = 4'd9; Wd_A = 18'h3C3C3; Ben_A = 2'b11;
        run_cycle();
        chk("t_clr_nognt", 32'(last_gnt_a), 32'd0);
        Clr_Start = 1'b0;
        repeat (NWORDS) run_cycle();
        chk("t_clr_busy_n", 32'(n_busy_seen - b0), 32'(NWORDS));
        chk("t_clr_done_n", 32'(n_done_seen - d0), 32'd1);
        run_cycle();
        chk("t_clr_gnt_after", 32'(last_gnt_a), 32'd1);

        // Clr_Start re-pulsed while clearing
        b0 = n_busy_seen; d0 = n_done_seen;
        Clr_Start = 1'b1;
        run_cycle();
        for (int i = 0; i < NWORDS + 2; i++) begin
            Clr_Start = (i == 3 || i == 10);
            run_cycle();
        end
        Clr_Start = 1'b0;
        chk("t_repulse_busy_n", 32'(n_busy_seen - b0), 32'(NWORDS));
        chk("t_repulse_done_n", 32'(n_done_seen - d0), 32'd1);

        // Reset while address 7 of a clear is on the bus
        d0 = n_done_seen;
        Clr_Start = 1'b1;
        run_cycle();
        Clr_Start = 1'b0;
        repeat (7) run_cycle();
        chk("t_rstclr_wa7", 32'(Mem_WA), 32'd7);
        Rst = 1'b1;
        run_cycle();
        Rst = 1'b0;
        chk("t_rstclr_busy", 32'(Clr_Busy), 32'd0);
        chk("t_rstclr_wen",  32'(Mem_WEN),  32'd0);
        chk("t_rstclr_wa",   32'(Mem_WA),   32'd0);
        repeat (NWORDS + 4) run_cycle();
        chk("t_rstclr_nodone", 32'(n_done_seen - d0), 32'd0);
        Req_A = 1'b1; We_A = 1'b1; Addr_A = 4'd12; Wd_A = 18'h00ABC; Ben_A = 2'b10;
        run_cycle();
        chk("t_rstclr_arb", 32'(last_gnt_a), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Rst       = ($urandom_range(0, 299) == 0);
            Clr_Start = ($urandom_range(0, 79) == 0);
            if (!Req_A && $urandom_range(0, 2) != 0) new_req_a();
            if (!Req_B && $urandom_range(0, 2) != 0) new_req_b();
            run_cycle();
        end
        Rst = 1'b0; Clr_Start = 1'b0; Req_A = 1'b0; Req_B = 1'b0;
        repeat (NWORDS + 6) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
